// File: rtl/window_line_buffer_pkg.sv
// window_line_buffer_pkg: shared types, widths and tap helper.
// Optional drop counter is enabled by WINDOW_DROP_COUNT_EN.
package window_line_buffer_pkg;

  function automatic int wlb_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int PIX_W      = 8;
  localparam int DEF_COL_W  = wlb_w(512);
  localparam int DEF_ROW_W  = wlb_w(512);
  localparam int DEF_SLOT_W = wlb_w(4);

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    ROW_END
  } rd_state_e;

  function automatic int tap_off(
    input int r,
    input int c,
    input int k,
    input int w
  );
    return (r * k + c) * w;
  endfunction

endpackage

// File: rtl/wlb_line_ram.sv
// wlb_line_ram: one image line, one write port, registered read.
// Read data holds when re is low so a stalled pipeline keeps it.
module wlb_line_ram
  import window_line_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 512,
  parameter int AW     = wlb_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // store one pixel per accepted write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // one-cycle read latency, held while not enabled
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/window_line_buffer.sv
// window_line_buffer: ring of K+1 line RAMs feeding a K x K window
// stream. Define WINDOW_DROP_COUNT_EN to add o_drop_count.
module window_line_buffer
  import window_line_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int K      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         i_pixel_data,
  input  logic                      i_pixel_valid,
  output logic                      o_pixel_ready,
  output logic [K*K*DATA_W-1:0]     o_window,
  output logic                      o_window_valid,
  input  logic                      i_window_ready,
  output logic                      o_line_free,
  output logic                      o_frame_done,
  output logic [wlb_w(IMG_H)-1:0]   o_out_row,
  output logic [wlb_w(IMG_W)-1:0]   o_out_col
`ifdef WINDOW_DROP_COUNT_EN
  ,
  output logic [15:0]               o_drop_count
`endif
);

  localparam int CW = wlb_w(IMG_W);
  localparam int HW = wlb_w(IMG_H);
  localparam int SW = wlb_w(K + 1);
  localparam int FW = wlb_w(K + 2);
  localparam int LW = wlb_w(IMG_H + 1);
  localparam int NS = K + 1;

  function automatic logic [SW-1:0] slot_add(
    input logic [SW-1:0] b,
    input int            r
  );
    int s;
    s = int'(b) + r;
    if (s >= NS) s = s - NS;
    return SW'(s);
  endfunction

  rd_state_e state_q, state_d;

  logic [CW-1:0] wcol;
  logic [SW-1:0] wslot;
  logic [FW-1:0] full_lines, full_d;
  logic [LW-1:0] lines_wr;
  logic          frame_written, fw_d;

  logic [SW-1:0] rbase;
  logic [HW-1:0] out_row;
  logic [CW-1:0] rcol, rdcol;
  logic          rd_done, rv;

  logic accept, line_done, en, issue;
  logic last_acc, frame_end, win_load;

  logic [DATA_W-1:0] rdata  [NS];
  logic [DATA_W-1:0] newcol [K];
  logic [DATA_W-1:0] sh     [K-1][K];
  logic [K*K*DATA_W-1:0] win_d;

  assign accept    = i_pixel_valid && o_pixel_ready;
  assign line_done = accept && (wcol == CW'(IMG_W - 1));
  assign en        = !o_window_valid || i_window_ready;
  assign last_acc  = o_window_valid && i_window_ready &&
                     (o_out_col == CW'(IMG_W - K));
  assign frame_end = (state_q == ROW_END) &&
                     (out_row == HW'(IMG_H - K));
  assign win_load  = rv && (rdcol >= CW'(K - 1));

  for (genvar s = 0; s < NS; s++) begin : g_ram
    wlb_line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .AW     (CW)
    ) u_ram (
      .clk   (clk),
      .we    (accept && (wslot == SW'(s))),
      .waddr (wcol),
      .wdata (i_pixel_data),
      .re    (issue),
      .raddr (rcol),
      .rdata (rdata[s])
    );
  end

  // read FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // read FSM next state, read issue and release pulses
  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    o_line_free  = 1'b0;
    o_frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full_lines >= FW'(K)) state_d = PRIME;
      end
      PRIME: begin
        issue = 1'b1;
        if (rcol == CW'(K - 2)) state_d = STREAM;
      end
      STREAM: begin
        issue = en && !rd_done;
        if (last_acc) state_d = ROW_END;
      end
      ROW_END: begin
        o_line_free  = 1'b1;
        o_frame_done = frame_end;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // net line occupancy: completion and release may cancel out
  always_comb begin
    full_d = full_lines;
    if (frame_end)
      full_d = '0;
    else if (line_done && !o_line_free)
      full_d = full_lines + 1'b1;
    else if (!line_done && o_line_free)
      full_d = full_lines - 1'b1;
  end

  // frame fully written until the last window leaves
  always_comb begin
    fw_d = frame_written;
    if (frame_end)
      fw_d = 1'b0;
    else if (line_done && (lines_wr == LW'(IMG_H - 1)))
      fw_d = 1'b1;
  end

  // occupancy, frame flag and ready, registered from next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_lines    <= '0;
      frame_written <= 1'b0;
      o_pixel_ready <= 1'b0;
    end else begin
      full_lines    <= full_d;
      frame_written <= fw_d;
      o_pixel_ready <= (full_d < FW'(K + 1)) && !fw_d;
    end
  end

  // write column, write slot and written-line count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcol     <= '0;
      wslot    <= '0;
      lines_wr <= '0;
    end else if (frame_end) begin
      wcol     <= '0;
      wslot    <= '0;
      lines_wr <= '0;
    end else if (accept) begin
      if (wcol == CW'(IMG_W - 1)) begin
        wcol     <= '0;
        wslot    <= slot_add(wslot, 1);
        lines_wr <= lines_wr + 1'b1;
      end else begin
        wcol <= wcol + 1'b1;
      end
    end
  end

  // read column, in-flight tag, oldest slot and output row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcol    <= '0;
      rdcol   <= '0;
      rd_done <= 1'b0;
      rv      <= 1'b0;
      rbase   <= '0;
      out_row <= '0;
    end else begin
      if (state_q == IDLE) begin
        rcol    <= '0;
        rd_done <= 1'b0;
      end else if (issue) begin
        rdcol <= rcol;
        if (rcol == CW'(IMG_W - 1)) rd_done <= 1'b1;
        else                        rcol    <= rcol + 1'b1;
      end
      if (en) rv <= issue;
      if (state_q == ROW_END) begin
        if (frame_end) begin
          rbase   <= '0;
          out_row <= '0;
        end else begin
          rbase   <= slot_add(rbase, 1);
          out_row <= out_row + 1'b1;
        end
      end
    end
  end

  // map the K oldest slots onto window rows, oldest first
  always_comb begin
    for (int r = 0; r < K; r++) begin
      newcol[r] = rdata[slot_add(rbase, r)];
    end
  end

  // assemble next window from held columns plus the new one
  always_comb begin
    win_d = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[tap_off(r, c, K, DATA_W) +: DATA_W] = sh[c][r];
      end
      win_d[tap_off(r, K - 1, K, DATA_W) +: DATA_W] = newcol[r];
    end
  end

  // column shift register and registered window output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < K - 1; c++) begin
        for (int r = 0; r < K; r++) sh[c][r] <= '0;
      end
      o_window       <= '0;
      o_window_valid <= 1'b0;
      o_out_row      <= '0;
      o_out_col      <= '0;
    end else if (en) begin
      if (rv) begin
        for (int c = 0; c < K - 2; c++) begin
          for (int r = 0; r < K; r++) sh[c][r] <= sh[c+1][r];
        end
        for (int r = 0; r < K; r++) sh[K-2][r] <= newcol[r];
      end
      o_window_valid <= win_load;
      if (win_load) begin
        o_window  <= win_d;
        o_out_col <= rdcol - CW'(K - 1);
        o_out_row <= out_row;
      end
    end
  end

`ifdef WINDOW_DROP_COUNT_EN
  // saturating count of cycles a pixel was offered but refused
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      o_drop_count <= '0;
    else if (i_pixel_valid && !o_pixel_ready &&
             (o_drop_count != 16'hFFFF))
      o_drop_count <= o_drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_window_line_buffer.sv
// tb_window_line_buffer: directed bench, IMG_W=8 IMG_H=6 K=3,
// pixel value = row*16 + col.
module tb_window_line_buffer;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int KK = 3;
  localparam int WW = KK * KK * DW;
  localparam int NWIN = (IH - KK + 1) * (IW - KK + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] i_pixel_data = '0;
  logic          i_pixel_valid = 1'b0;
  logic          o_pixel_ready;
  logic [WW-1:0] o_window;
  logic          o_window_valid;
  logic          i_window_ready = 1'b0;
  logic          o_line_free;
  logic          o_frame_done;
  logic [2:0]    o_out_row;
  logic [2:0]    o_out_col;
`ifdef WINDOW_DROP_COUNT_EN
  logic [15:0]   o_drop_count;
`endif

  window_line_buffer #(
    .DATA_W (DW),
    .IMG_W  (IW),
    .IMG_H  (IH),
    .K      (KK)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_pixel_data   (i_pixel_data),
    .i_pixel_valid  (i_pixel_valid),
    .o_pixel_ready  (o_pixel_ready),
    .o_window       (o_window),
    .o_window_valid (o_window_valid),
    .i_window_ready (i_window_ready),
    .o_line_free    (o_line_free),
    .o_frame_done   (o_frame_done),
    .o_out_row      (o_out_row),
    .o_out_col      (o_out_col)
`ifdef WINDOW_DROP_COUNT_EN
    ,
    .o_drop_count   (o_drop_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [WW-1:0] win_q [$];
  int row_q [$];
  int col_q [$];
  int px_r, px_c, n_acc, px_limit, frames_left;
  int n_lf, n_fd, fd_at, cyc, rdy_mode;
  bit feed_en, lf_now, acc_now;

  function automatic logic [WW-1:0] exp_win(input int row, input int col);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < KK; r++)
      for (int c = 0; c < KK; c++)
        w[(r*KK+c)*DW +: DW] = DW'((row + r) * 16 + col + c);
    return w;
  endfunction

  task automatic clear_bench(input int frames);
    win_q.delete();
    row_q.delete();
    col_q.delete();
    px_r = 0; px_c = 0; n_acc = 0; px_limit = 0;
    frames_left = frames; feed_en = 1'b1;
    n_lf = 0; n_fd = 0; fd_at = -1; cyc = 0;
  endtask

  // one cycle: observe at negedge, drive, log what the next edge takes
  task automatic step();
    @(negedge clk);
    lf_now = o_line_free;
    if (o_line_free) n_lf++;
    if (o_frame_done) begin
      n_fd++;
      fd_at = win_q.size();
    end
    case (rdy_mode)
      0:       i_window_ready = 1'b1;
      1:       i_window_ready = !i_window_ready;
      default: i_window_ready = 1'b0;
    endcase
    i_pixel_valid = feed_en && (frames_left > 0) &&
                    (px_limit == 0 || n_acc < px_limit);
    i_pixel_data = DW'(px_r * 16 + px_c);
    acc_now = i_pixel_valid && o_pixel_ready;
    if (o_window_valid && i_window_ready) begin
      win_q.push_back(o_window);
      row_q.push_back(int'(o_out_row));
      col_q.push_back(int'(o_out_col));
    end
    if (acc_now) begin
      n_acc++;
      if (px_c == IW - 1) begin
        px_c = 0;
        if (px_r == IH - 1) begin
          px_r = 0;
          frames_left--;
        end else px_r++;
      end else px_c++;
    end
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (o_pixel_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_ready got %0b want 0", o_pixel_ready);
    end
    tests++;
    if (o_window_valid !== 1'b0 || o_window !== '0) begin
      fails++;
      $display("FAIL rst_window got %0b/%h want 0/0",
               o_window_valid, o_window);
    end
    tests++;
    if ({o_line_free, o_frame_done} !== 2'b00) begin
      fails++;
      $display("FAIL rst_pulses got %b want 00",
               {o_line_free, o_frame_done});
    end
    tests++;
    if (o_out_row !== 3'd0 || o_out_col !== 3'd0) begin
      fails++;
      $display("FAIL rst_rowcol got %0d,%0d want 0,0",
               o_out_row, o_out_col);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (o_pixel_ready !== 1'b1) begin
      fails++;
      $display("FAIL post_rst_ready got %0b want 1", o_pixel_ready);
    end
  endtask

  task automatic test_stream();
    clear_bench(1);
    rdy_mode = 0;
    while (n_fd < 1 && cyc < 3000) step();
    tests++;
    if (n_fd < 1) begin
      fails++;
      $display("FAIL stream_timeout got %0d frames want 1", n_fd);
    end
    repeat (4) step();
    tests++;
    if (win_q.size() !== NWIN) begin
      fails++;
      $display("FAIL stream_count got %0d want %0d",
               win_q.size(), NWIN);
    end
    tests++;
    if (win_q.size() == 0 || win_q[0] !== exp_win(0, 0)) begin
      fails++;
      $display("FAIL stream_first got %h want %h",
               (win_q.size() > 0) ? win_q[0] : '0, exp_win(0, 0));
    end
    for (int i = 0; i < win_q.size(); i++) begin
      tests++;
      if (win_q[i] !== exp_win(i / 6, i % 6) ||
          row_q[i] !== i / 6 || col_q[i] !== i % 6) begin
        fails++;
        $display("FAIL stream_win%0d got %h r%0d c%0d want %h r%0d c%0d",
                 i, win_q[i], row_q[i], col_q[i],
                 exp_win(i / 6, i % 6), i / 6, i % 6);
      end
    end
    tests++;
    if (n_fd !== 1 || fd_at !== NWIN) begin
      fails++;
      $display("FAIL stream_frame_done got n=%0d at=%0d want 1 at %0d",
               n_fd, fd_at, NWIN);
    end
    tests++;
    if (n_lf !== IH - KK + 1) begin
      fails++;
      $display("FAIL stream_line_free got %0d want %0d",
               n_lf, IH - KK + 1);
    end
    tests++;
    if (o_pixel_ready !== 1'b1) begin
      fails++;
      $display("FAIL stream_ready_after got %0b want 1", o_pixel_ready);
    end
  endtask

  task automatic test_backpressure();
    clear_bench(1);
    rdy_mode = 0;
    while (win_q.size() < 1 && cyc < 500) step();
    rdy_mode = 2;
    while (cyc < 800 && !(n_acc == 32 && o_pixel_ready === 1'b0))
      step();
    repeat (10) step();
    tests++;
    if (n_acc !== 32 || o_pixel_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_full got acc=%0d rdy=%0b want 32/0",
               n_acc, o_pixel_ready);
    end
    rdy_mode = 0;
    lf_now = 1'b0;
    while (!lf_now && cyc < 1200) step();
    tests++;
    if (!lf_now || acc_now || n_acc !== 32) begin
      fails++;
      $display("FAIL bp_lf_cycle got lf=%0b acc=%0d want lf=1 acc=32",
               lf_now, n_acc);
    end
    step();
    tests++;
    if (!acc_now || n_acc !== 33) begin
      fails++;
      $display("FAIL bp_held_pixel got acc=%0d want 33", n_acc);
    end
    while (n_fd < 1 && cyc < 4000) step();
    tests++;
    if (n_fd !== 1 || win_q.size() !== NWIN) begin
      fails++;
      $display("FAIL bp_frame got fd=%0d n=%0d want 1/%0d",
               n_fd, win_q.size(), NWIN);
    end
    for (int i = 0; i < win_q.size(); i++) begin
      tests++;
      if (win_q[i] !== exp_win(i / 6, i % 6)) begin
        fails++;
        $display("FAIL bp_win%0d got %h want %h",
                 i, win_q[i], exp_win(i / 6, i % 6));
      end
    end
  endtask

  task automatic test_toggle_ready();
    logic          pv, pr;
    logic [WW-1:0] pw;
    clear_bench(1);
    rdy_mode = 1;
    i_window_ready = 1'b0;
    while (n_fd < 1 && cyc < 4000) begin
      pv = o_window_valid;
      pr = i_window_ready;
      pw = o_window;
      step();
      if (pv && !pr) begin
        tests++;
        if (o_window_valid !== 1'b1 || o_window !== pw) begin
          fails++;
          $display("FAIL toggle_hold got %0b/%h want 1/%h",
                   o_window_valid, o_window, pw);
        end
      end
    end
    tests++;
    if (n_fd !== 1 || win_q.size() !== NWIN) begin
      fails++;
      $display("FAIL toggle_frame got fd=%0d n=%0d want 1/%0d",
               n_fd, win_q.size(), NWIN);
    end
    for (int i = 0; i < win_q.size(); i++) begin
      tests++;
      if (win_q[i] !== exp_win(i / 6, i % 6) ||
          row_q[i] !== i / 6 || col_q[i] !== i % 6) begin
        fails++;
        $display("FAIL toggle_win%0d got %h want %h",
                 i, win_q[i], exp_win(i / 6, i % 6));
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_bench(1);
    rdy_mode = 0;
    while (cyc < 2000 && !(row_q.size() > 0 &&
           row_q[$] == 2 && col_q[$] == 2)) step();
    tests++;
    if (row_q.size() == 0 || row_q[$] != 2) begin
      fails++;
      $display("FAIL mrst_reach got %0d windows want row 2",
               row_q.size());
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (o_window_valid !== 1'b0 || o_window !== '0 ||
        o_pixel_ready !== 1'b0) begin
      fails++;
      $display("FAIL mrst_outs got v=%0b w=%h r=%0b want 0",
               o_window_valid, o_window, o_pixel_ready);
    end
    tests++;
    if (o_out_row !== 3'd0 || o_out_col !== 3'd0 ||
        o_line_free !== 1'b0 || o_frame_done !== 1'b0) begin
      fails++;
      $display("FAIL mrst_rowcol got %0d,%0d want 0,0",
               o_out_row, o_out_col);
    end
    i_pixel_valid = 1'b0;
    i_window_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_bench(1);
    while (win_q.size() < 1 && cyc < 500) step();
    tests++;
    if (win_q.size() == 0 || win_q[0] !== exp_win(0, 0) ||
        row_q[0] !== 0 || col_q[0] !== 0) begin
      fails++;
      $display("FAIL mrst_first got %h want %h",
               (win_q.size() > 0) ? win_q[0] : '0, exp_win(0, 0));
    end
    while (n_fd < 1 && cyc < 3000) step();
    tests++;
    if (n_fd !== 1 || win_q.size() !== NWIN) begin
      fails++;
      $display("FAIL mrst_frame got fd=%0d n=%0d want 1/%0d",
               n_fd, win_q.size(), NWIN);
    end
  endtask

  task automatic test_back_to_back();
    clear_bench(2);
    rdy_mode = 0;
    while (n_fd < 2 && cyc < 6000) step();
    tests++;
    if (n_fd !== 2 || win_q.size() !== 2 * NWIN) begin
      fails++;
      $display("FAIL b2b_frames got fd=%0d n=%0d want 2/%0d",
               n_fd, win_q.size(), 2 * NWIN);
    end
    tests++;
    if (win_q.size() <= NWIN || win_q[NWIN] !== exp_win(0, 0)) begin
      fails++;
      $display("FAIL b2b_second_first got %h want %h",
               (win_q.size() > NWIN) ? win_q[NWIN] : '0,
               exp_win(0, 0));
    end
    for (int i = 0; i < win_q.size(); i++) begin
      tests++;
      if (win_q[i] !== exp_win((i % NWIN) / 6, i % 6) ||
          row_q[i] !== (i % NWIN) / 6 || col_q[i] !== i % 6) begin
        fails++;
        $display("FAIL b2b_win%0d got %h want %h", i, win_q[i],
                 exp_win((i % NWIN) / 6, i % 6));
      end
    end
  endtask

`ifdef WINDOW_DROP_COUNT_EN
  task automatic test_drop_count();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_bench(1);
    rdy_mode = 2;
    px_limit = 32;
    while (cyc < 800 && !(n_acc == 32 && o_pixel_ready === 1'b0))
      step();
    repeat (3) step();
    feed_en = 1'b0;
    step();
    tests++;
    if (o_drop_count !== 16'd0 || o_pixel_ready !== 1'b0) begin
      fails++;
      $display("FAIL drop_pre got %0d rdy=%0b want 0/0",
               o_drop_count, o_pixel_ready);
    end
    repeat (5) begin
      @(negedge clk);
      i_pixel_valid = 1'b1;
    end
    @(negedge clk);
    i_pixel_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (o_drop_count !== 16'd5) begin
      fails++;
      $display("FAIL drop_count got %0d want 5", o_drop_count);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
`endif

  initial begin
    rdy_mode = 0;
    clear_bench(0);
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle_ready();
    test_mid_reset();
    test_back_to_back();
`ifdef WINDOW_DROP_COUNT_EN
    test_drop_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
- Parametrised successor of the pixel-ingest/line-buffer stage between the UART RX FIFO and the Sobel kernel.
- Accepts a raster pixel stream, stores K+1 image lines in a ring of line RAMs, and emits K×K pixel windows over a valid/ready stream.
- Signals upstream when a line slot frees and when a frame completes.
- Generalises width, kernel size and image geometry, and adds output backpressure.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 512, pixels per line (≥K)
- IMG_H, 512, lines per frame (≥K)
- K, 3, window edge (odd, 3..7)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- i_pixel_data  in  DATA_W  raster pixel
- i_pixel_valid  in  1  pixel present
- o_pixel_ready  out  1  pixel accepted when valid&&ready
- o_window  out  K*K*DATA_W  window; tap (r,c) at bits [(r*K+c)*DATA_W +: DATA_W], r=0 oldest line, c=0 leftmost column
- o_window_valid  out  1  window present
- i_window_ready  in  1  downstream accepts
- o_line_free  out  1  one-cycle pulse when a line slot is released
- o_frame_done  out  1  one-cycle pulse after last window of frame accepted
- o_out_row  out  clog2(IMG_H)  output row of current window
- o_out_col  out  clog2(IMG_W)  output column of current window

Behaviour:
- Reset (async, active-high): all outputs 0; fill count, write/read pointers and FSM cleared. Mid-frame reset discards all buffered lines; the next accepted pixel is pixel (0,0).
- Write side:
  - Write column wcol and slot wslot (0..K).
  - On accept, store to line_ram[wslot][wcol]; wcol wraps at IMG_W-1, then wslot advances mod K+1 and full_lines increments.
  - o_pixel_ready = (full_lines < K+1) && !(frame_written).
  - frame_written sets after IMG_H lines are accepted and clears on o_frame_done.
- Read FSM states:
  - IDLE: wait full_lines ≥ K → PRIME.
  - PRIME: read columns 0..K-2 from the K oldest slots into the K×K shift window. The RAM read has 1-cycle latency. Then → STREAM.
  - STREAM: each read shifts one column in. o_window_valid is registered. While valid && !ready, o_window and o_window_valid hold and the read pipeline stalls. After col IMG_W-1 is accepted → ROW_END.
  - ROW_END: release the oldest slot (full_lines−1, o_line_free pulse), increment out_row. If out_row reaches IMG_H-K+1, pulse o_frame_done, flush full_lines to 0, reset pointers → IDLE. Otherwise → IDLE.
- Output per frame: IMG_H-K+1 rows × IMG_W-K+1 windows. o_out_col runs 0..IMG_W-K; o_out_row runs 0..IMG_H-K.
- Latency: first window valid K+1 cycles after IDLE→PRIME (K-1 prime reads, 1 RAM latency, 1 output register).
- Simultaneous line completion on write and slot release on read in the same cycle: full_lines net unchanged, and o_pixel_ready does not drop.
- Write never overwrites a slot in use, guaranteed by full_lines ≤ K+1. The slot being read is never the write slot.
- Pixels offered while o_pixel_ready=0 are not accepted. Upstream must hold them.
- Arithmetic: pointer widths clog2(K+1), clog2(IMG_W), clog2(IMG_H). Counters wrap only at the stated bounds, never by natural overflow.

Optional Feature:
- Macro WINDOW_DROP_COUNT_EN.
- Defined: adds output o_drop_count (16 bits), incremented each cycle i_pixel_valid && !o_pixel_ready. It saturates at 0xFFFF, resets to 0 on reset, and is not cleared by frame_done.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - pixel_t (DATA_W vector)
  - read-FSM state enum (IDLE, PRIME, STREAM, ROW_END)
  - clog2-derived width constants
  - tap index function (r,c)→bit offset
- One sub-module: wlb_line_ram, a simple dual-port RAM (IMG_W×DATA_W) with 1 write port and a registered read, instantiated K+1 times.

Test Plan (IMG_W=8, IMG_H=6, K=3, pixel value = row*16+col):
- Continuous stream, i_window_ready=1 → 4 rows × 6 windows. The first window has taps 0x00,0x01,0x02 / 0x10,0x11,0x12 / 0x20,0x21,0x22. o_frame_done pulses once after the window at row 3, col 5.
- Input runs 2 lines ahead with no reads (i_window_ready=0 after the first window) → o_pixel_ready drops once 4 slots are full. The held pixel is accepted the cycle after the first o_line_free.
- i_window_ready toggled 1/0 each cycle → o_window stays stable while stalled. Window sequence is identical to scenario 1, with no duplicates or skips.
- Reset asserted mid-row 2 of the output, then a fresh frame → outputs go 0 immediately. The new frame's first window equals scenario 1's first window.
- Back-to-back frames → the second frame's first window equals 0x00..0x22. There is no gap beyond the K+1-cycle prime latency.
- WINDOW_DROP_COUNT_EN: hold i_pixel_valid=1 for 5 cycles while o_pixel_ready=0 → o_drop_count=5.
